// File: rtl/mem_if_defs_pkg.sv
// Shared definitions for the burst master: FSM state encoding, active-low
// memory enable levels and default interface widths.
package mem_if_defs;

    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefLenWidth  = 8;

    // Mem_En and Write_EN are active low on the memory side
    localparam logic MemOn  = 1'b0;
    localparam logic MemOff = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StWaitW  = 2'b01,
        StAccess = 2'b10
    } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Beat address register and remaining-beat down-counter for one burst.
// The address wraps modulo 2^AddrWidth; last_o flags the final beat.
module mem_addr_gen
    import mem_if_defs::*;
#(
    parameter int unsigned AddrWidth = DefAddrWidth,
    parameter int unsigned LenWidth  = DefLenWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [AddrWidth-1:0] base_i,
    input  logic [LenWidth-1:0]  len_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 last_o
);

    logic [AddrWidth-1:0] addr_d, addr_q;
    logic [LenWidth-1:0]  count_d, count_q;

    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (load_i) begin
            addr_d  = base_i;
            count_d = len_i;
        end else if (step_i) begin
            addr_d  = addr_q + AddrWidth'(1);
            count_d = count_q - LenWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (count_q == '0);

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port, active-low-enable memory that acts on
// the negedge. All memory-side outputs are registered on the posedge.
module mem_burst_master
    import mem_if_defs::*;
#(
    parameter int unsigned AddrWidth = DefAddrWidth,
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned LenWidth  = DefLenWidth
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 Start,
    input  logic                 Wr,
    input  logic [AddrWidth-1:0] Base_Addr,
    input  logic [LenWidth-1:0]  Len,
    input  logic [DataWidth-1:0] WData,
    input  logic                 WValid,
    output logic                 WReady,
    output logic [DataWidth-1:0] RData,
    output logic                 RValid,
    output logic                 Busy,
    output logic                 Done,
    output logic [AddrWidth-1:0] Mem_Addr,
    output logic [DataWidth-1:0] Mem_DIn,
    output logic                 Mem_Write_EN,
    output logic                 Mem_En,
    input  logic [DataWidth-1:0] Mem_DOut
);

    state_e               state_d, state_q;
    logic                 wr_d, wr_q;
    logic                 mem_en_d, mem_en_q;
    logic                 mem_we_d, mem_we_q;
    logic [DataWidth-1:0] mem_din_d, mem_din_q;
    logic [DataWidth-1:0] rdata_d, rdata_q;
    logic                 rvalid_d, rvalid_q;
    logic                 done_d, done_q;
    logic                 load, step, last;

    mem_addr_gen #(
        .AddrWidth(AddrWidth),
        .LenWidth (LenWidth)
    ) u_addr_gen (
        .clk_i (Clk),
        .rst_ni(Reset_N),
        .load_i(load),
        .step_i(step),
        .base_i(Base_Addr),
        .len_i (Len),
        .addr_o(Mem_Addr),
        .last_o(last)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        mem_en_d  = mem_en_q;
        mem_we_d  = mem_we_q;
        mem_din_d = mem_din_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        done_d    = 1'b0;
        load      = 1'b0;
        step      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    wr_d = Wr;
                    load = 1'b1;
                    if (Wr) begin
                        state_d = StWaitW;
                    end else begin
                        mem_en_d = MemOn;
                        mem_we_d = MemOff;
                        state_d  = StAccess;
                    end
                end
            end
            StWaitW: begin
                if (WValid) begin
                    mem_din_d = WData;
                    mem_en_d  = MemOn;
                    mem_we_d  = MemOn;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                // Memory completed this beat at the mid-cycle negedge
                if (!wr_q) begin
                    rdata_d  = Mem_DOut;
                    rvalid_d = 1'b1;
                end
                if (last) begin
                    mem_en_d = MemOff;
                    mem_we_d = MemOff;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    step = 1'b1;
                    if (wr_q) begin
                        mem_en_d = MemOff;
                        mem_we_d = MemOff;
                        state_d  = StWaitW;
                    end
                end
            end
            default: begin
                mem_en_d = MemOff;
                mem_we_d = MemOff;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q   <= StIdle;
            wr_q      <= 1'b0;
            mem_en_q  <= MemOff;
            mem_we_q  <= MemOff;
            mem_din_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            mem_din_q <= mem_din_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
        end
    end

    assign Busy         = (state_q != StIdle);
    assign WReady       = (state_q == StWaitW);
    assign RData        = rdata_q;
    assign RValid       = rvalid_q;
    assign Done         = done_q;
    assign Mem_DIn      = mem_din_q;
    assign Mem_Write_EN = mem_we_q;
    assign Mem_En       = mem_en_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural 256x16 negedge memory.
module tb_mem_burst_master;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        Start, Wr, WValid;
    logic [7:0]  Base_Addr, Len;
    logic [15:0] WData;
    logic        WReady, RValid, Busy, Done, Mem_Write_EN, Mem_En;
    logic [15:0] RData, Mem_DIn, Mem_DOut;
    logic [7:0]  Mem_Addr;

    logic [15:0] mem [256];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 Clk = ~Clk;

    mem_burst_master dut (
        .Clk         (Clk),
        .Reset_N     (Reset_N),
        .Start       (Start),
        .Wr          (Wr),
        .Base_Addr   (Base_Addr),
        .Len         (Len),
        .WData       (WData),
        .WValid      (WValid),
        .WReady      (WReady),
        .RData       (RData),
        .RValid      (RValid),
        .Busy        (Busy),
        .Done        (Done),
        .Mem_Addr    (Mem_Addr),
        .Mem_DIn     (Mem_DIn),
        .Mem_Write_EN(Mem_Write_EN),
        .Mem_En      (Mem_En),
        .Mem_DOut    (Mem_DOut)
    );

    always @(negedge Clk) begin
        if (!Mem_En) begin
            if (!Mem_Write_EN) mem[Mem_Addr] <= Mem_DIn;
            else               Mem_DOut <= mem[Mem_Addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next posedge; outputs are then stable for sampling
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_cmd(input logic wr, input logic [7:0] base, input logic [7:0] len);
        Start = 1'b1; Wr = wr; Base_Addr = base; Len = len;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        Reset_N = 1'b0; Start = 1'b0; Wr = 1'b0; WValid = 1'b0;
        Base_Addr = '0; Len = '0; WData = '0; Mem_DOut = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'hBEEF;
        mem[8'hFE] = 16'h1111;
        mem[8'hFF] = 16'h2222;
        mem[8'h00] = 16'h3333;
        mem[8'h40] = 16'h4040;
        mem[8'h41] = 16'h4141;

        // Reset values
        tick(); tick();
        check("rst_mem_en", 32'(Mem_En), 32'h1);
        check("rst_mem_we", 32'(Mem_Write_EN), 32'h1);
        check("rst_addr", 32'(Mem_Addr), 32'h0);
        check("rst_din", 32'(Mem_DIn), 32'h0);
        check("rst_rdata", 32'(RData), 32'h0);
        check("rst_flags", 32'({RValid, Done, Busy, WReady}), 32'h0);
        Reset_N = 1'b1;
        tick();

        // Single read of 0x10
        start_cmd(1'b0, 8'h10, 8'd0);
        check("rd1_c1_busy", 32'(Busy), 32'h1);
        check("rd1_c1_en", 32'(Mem_En), 32'h0);
        check("rd1_c1_addr", 32'(Mem_Addr), 32'h10);
        check("rd1_c1_rvalid", 32'(RValid), 32'h0);
        tick();
        check("rd1_c2_rdata", 32'(RData), 32'hBEEF);
        check("rd1_c2_flags", 32'({RValid, Done, Busy, Mem_En}), 32'b1101);
        tick();
        check("rd1_c3_flags", 32'({RValid, Done, Busy}), 32'h0);

        // Read burst wrapping 0xFE -> 0x00
        start_cmd(1'b0, 8'hFE, 8'd2);
        check("rdw_c1_addr", 32'(Mem_Addr), 32'hFE);
        tick();
        check("rdw_c2", 32'({RValid, Done, RData, Mem_Addr}), {8'h0, 1'b1, 1'b0, 16'h1111, 8'hFF});
        tick();
        check("rdw_c3", 32'({RValid, Done, RData, Mem_Addr}), {8'h0, 1'b1, 1'b0, 16'h2222, 8'h00});
        tick();
        check("rdw_c4", 32'({RValid, Done, Busy, RData}), {13'h0, 3'b110, 16'h3333});
        tick();

        // Write burst with a 3-cycle stall before the second beat
        start_cmd(1'b1, 8'h20, 8'd1);
        check("wr_c1", 32'({WReady, Mem_En, Mem_Write_EN, Busy}), 32'b1111);
        WValid = 1'b1; WData = 16'hA5A5;
        tick();
        WValid = 1'b0; WData = 16'h0;
        check("wr_b0_acc", 32'({WReady, Mem_En, Mem_Write_EN, Mem_DIn}), {13'h0, 3'b000, 16'hA5A5});
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wr_stall", 32'({WReady, Mem_En, Done, Mem_Addr}), {21'h0, 3'b110, 8'h21});
            tick();
        end
        WValid = 1'b1; WData = 16'h5A5A;
        tick();
        WValid = 1'b0;
        check("wr_b1_acc", 32'({Mem_En, Mem_Write_EN, Mem_DIn}), {14'h0, 2'b00, 16'h5A5A});
        tick();
        check("wr_done", 32'({Done, Busy, Mem_En, Mem_Write_EN}), 32'b1011);
        tick();
        check("wr_done_once", 32'(Done), 32'h0);
        check("wr_mem20", 32'(mem[8'h20]), 32'hA5A5);
        check("wr_mem21", 32'(mem[8'h21]), 32'h5A5A);

        // Back-to-back: Start while Busy ignored, Start in Done cycle accepted
        start_cmd(1'b0, 8'h10, 8'd0);
        Start = 1'b1; Base_Addr = 8'hFE; Len = 8'd3;
        tick();
        check("b2b_c2", 32'({RValid, Done, Busy, RData}), {13'h0, 3'b110, 16'hBEEF});
        Base_Addr = 8'hFF; Len = 8'd0;
        tick();
        Start = 1'b0;
        check("b2b_c3", 32'({RValid, Done, Busy, Mem_Addr}), {21'h0, 3'b001, 8'hFF});
        tick();
        check("b2b_c4", 32'({RValid, Done, Busy, RData}), {13'h0, 3'b110, 16'h2222});
        tick();
        check("b2b_c5", 32'({RValid, Done, Busy}), 32'h0);

        // Reset in the middle of an 8-beat read
        start_cmd(1'b0, 8'h40, 8'd7);
        tick();
        check("rrst_c2", 32'({RValid, RData}), {15'h0, 1'b1, 16'h4040});
        Reset_N = 1'b0;
        #1;
        check("rrst_now", 32'({Mem_En, RValid, Busy, Done, Mem_Addr}), {20'h0, 4'b1000, 8'h00});
        tick();
        Reset_N = 1'b1;
        tick();
        check("rrst_after", 32'({Mem_En, RValid, Busy, Done}), 32'b1000);
        start_cmd(1'b0, 8'h10, 8'd0);
        tick();
        check("rrst_restart", 32'({RValid, Done, RData}), {14'h0, 2'b11, 16'hBEEF});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
Initiator side of the single-port, active-low-enable, negedge-sampled memory interface. It accepts single or burst read/write commands from a client (CPU/sequencer) and drives Address/DIn/Write_EN/Mem_En toward the memory. It captures synchronous read data and returns it with a valid strobe. Sits between the control unit and the 256x16 memory block.

Parameters:
AddrWidth, 8, memory address width; address wraps modulo 2^AddrWidth
DataWidth, 16, memory data width
LenWidth, 8, burst length field width (Len = beats-1)

Ports:
Clk  in  1  system clock; this block updates on posedge, memory acts on the negedge within the same cycle
Reset_N  in  1  asynchronous, active-low reset
Start  in  1  command strobe; sampled only in IDLE
Wr  in  1  1=write burst, 0=read burst; latched at Start
Base_Addr  in  AddrWidth  first beat address; latched at Start
Len  in  LenWidth  beats-1; latched at Start
WData  in  DataWidth  write beat data
WValid  in  1  client has write beat
WReady  out  1  block accepts write beat (=state WAIT_W)
RData  out  DataWidth  captured read beat
RValid  out  1  one-cycle pulse per read beat
Busy  out  1  state != IDLE
Done  out  1  one-cycle pulse after final beat completes
Mem_Addr  out  AddrWidth  to memory Address
Mem_DIn  out  DataWidth  to memory DIn
Mem_Write_EN  out  1  to memory Write_EN, active low
Mem_En  out  1  to memory Mem_En, active low
Mem_DOut  in  DataWidth  from memory DOut (registered at negedge)

Behaviour:
- Reset (async, Reset_N=0): state IDLE; Mem_En=1, Mem_Write_EN=1, Mem_Addr=0, Mem_DIn=0, RData=0, RValid=0, Done=0, Busy=0, WReady=0. All memory-side outputs are registered.
- IDLE: memory disabled (Mem_En=1, Mem_Write_EN=1). On Start=1, the block latches Wr, sets Mem_Addr=Base_Addr and Count=Len.
  - Read: Mem_En<=0, Mem_Write_EN<=1, go to ACCESS.
  - Write: go to WAIT_W.
- WAIT_W: WReady=1, memory disabled. On WValid=1 at posedge: Mem_DIn<=WData, Mem_En<=0, Mem_Write_EN<=0, go to ACCESS. WValid=0 stalls indefinitely.
- ACCESS: lasts exactly one cycle. The memory performs the access at the mid-cycle negedge. At the next posedge:
  - Read: RData<=Mem_DOut, RValid<=1.
  - If Count==0: Mem_En<=1, Mem_Write_EN<=1, Done<=1, go to IDLE.
  - Else Mem_Addr<=Mem_Addr+1 (0xFF->0x00 wraps, no error) and Count<=Count-1.
    - Read: stay in ACCESS with Mem_En held 0 (1 beat/cycle).
    - Write: Mem_En<=1, Mem_Write_EN<=1, go to WAIT_W (min 2 cycles/beat).
- Read latency: Start at edge 0 gives RValid on cycles 2..N+1 for N=Len+1 beats. Done and the last RValid coincide in cycle N+1, with Busy=0 in that cycle.
- Write timing: Done asserts the cycle after the final write ACCESS.
- Start while Busy is ignored. Start in the Done cycle is accepted, since state is IDLE.
- Len=2^LenWidth-1 gives a full 256-beat burst covering every address once.
- Mem_Write_EN never changes while Mem_En=0 within a beat. No read and write mix in one burst.
- Reset mid-burst: outputs drop to reset values immediately. A write whose negedge has not yet occurred is aborted. No Done is issued.

Decomposition:
- Shared package/include (mem_if_defs): state encodings (IDLE, WAIT_W, ACCESS), active-low enable constants (MEM_ON=0, MEM_OFF=1), default widths.
- One sub-module: mem_addr_gen. It holds the address register and beat down-counter, with load, step, and a Last flag (Count==0).

Test Plan:
- Single read: memory preloaded mem[0x10]=0xBEEF, Start Wr=0 Base_Addr=0x10 Len=0 -> Mem_En low for one cycle; RValid and Done in cycle 2 with RData=0xBEEF; Busy high cycle 1 only.
- Read burst wrap: mem[0xFE]=0x1111, mem[0xFF]=0x2222, mem[0x00]=0x3333; Base_Addr=0xFE Len=2 -> RValid cycles 2,3,4 with 0x1111, 0x2222, 0x3333; Done in cycle 4.
- Write burst with stall: Base_Addr=0x20 Len=1, WData 0xA5A5 then 0x5A5A, WValid withheld 3 cycles before beat 2 -> mem[0x20]=0xA5A5 and mem[0x21]=0x5A5A; Mem_En stays high during the stall; Done once.
- Back-to-back: Start asserted in the Done cycle of a read -> new command accepted, Busy re-asserts next cycle; Start pulses while Busy are ignored (no extra RValid).
- Reset mid-burst: Reset_N low during cycle 2 of a Len=7 read -> Mem_En=1 and RValid=0 immediately; no Done; a following Start works normally.
